// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Sequences the address register (AR) and the memory strobes for two
//   requesters: instruction fetch (PC path) and data access (bus path).
//   One transaction is LOAD (1 cycle) -> WAIT (MEM_LAT cycles) -> DONE
//   (1 cycle, ack pulse) -> IDLE. When both requesters ask in IDLE, the one
//   not served last wins. After reset, fetch wins the first tie.
//
// Parameters
//   reg_width   address width of the sequenced AR (interface bookkeeping)
//   MEM_LAT     memory access cycles after the AR load, 1..15
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   fetch_req    fetch request, level, held until fetch_ack
//   data_req     data request, level, held until data_ack
//   data_we      data access type (1 = write), sampled with the data grant
//   pc_en        AR load from pc_datain (fetch LOAD cycle)
//   ar_write_en  AR load from bus_datain (data LOAD cycle)
//   mem_rd       memory read strobe (WAIT, fetch or data read)
//   mem_wr       memory write strobe (WAIT, data write)
//   fetch_ack    one-cycle fetch completion pulse
//   data_ack     one-cycle data completion pulse
//   busy         high in every state except IDLE
//   grant_data   current owner, 1 = data, 0 = fetch; valid while busy
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int reg_width = 12,
    parameter int MEM_LAT   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    output logic pc_en,
    output logic ar_write_en,
    output logic mem_rd,
    output logic mem_wr,
    output logic fetch_ack,
    output logic data_ack,
    output logic busy,
    output logic grant_data
);

    // Parameter sanity: the 4-bit wait counter covers MEM_LAT 1..15 only.
    if (MEM_LAT < 1 || MEM_LAT > 15 || reg_width < 1) begin : g_bad_param
        $error("mem_arbiter: MEM_LAT must be 1..15 and reg_width >= 1");
    end

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       grant_q;    // latched owner, 1 = data
    logic       we_q;       // latched data_we, only meaningful for data owner
    logic       last_data;  // owner of the last completed transaction
    logic       req_any;
    logic       pick_data;

    // Arbitration decision, used only while in IDLE. Data wins when it is
    // the sole requester, or on a tie when fetch was served last.
    always_comb begin
        req_any   = fetch_req | data_req;
        pick_data = data_req & (~fetch_req | ~last_data);
    end

    // State register plus the transaction-scoped flags and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            last_data <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_q <= pick_data;
                        we_q    <= pick_data & data_we;
                    end
                end
                LOAD: begin
                    cnt <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_data <= grant_q;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. Requests are looked at only in IDLE, so a request
    // dropped mid-transaction cannot abort it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state and latched flags.
    always_comb begin
        pc_en       = 1'b0;
        ar_write_en = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        fetch_ack   = 1'b0;
        data_ack    = 1'b0;
        busy        = (state != IDLE);
        grant_data  = grant_q;
        case (state)
            LOAD: begin
                pc_en       = ~grant_q;
                ar_write_en = grant_q;
            end
            WAIT: begin
                mem_rd = ~(grant_q & we_q);
                mem_wr = grant_q & we_q;
            end
            DONE: begin
                fetch_ack = ~grant_q;
                data_ack  = grant_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Cycle 0 is the cycle in which the
//   requests are first presented after reset release; outputs are sampled
//   1 time unit after each rising edge. A second instance with MEM_LAT=1
//   exercises the shortest legal latency.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic fetch_req;
    logic data_req;
    logic data_we;

    logic pc_en, ar_write_en, mem_rd, mem_wr, fetch_ack, data_ack, busy, grant_data;
    logic pc_en1, ar_write_en1, mem_rd1, mem_wr1, fetch_ack1, data_ack1, busy1, grant_data1;

    int unsigned pass_cnt = 0;
    int unsigned total    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.reg_width(12), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
        .pc_en(pc_en), .ar_write_en(ar_write_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .fetch_ack(fetch_ack), .data_ack(data_ack),
        .busy(busy), .grant_data(grant_data)
    );

    mem_arbiter #(.reg_width(12), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
        .pc_en(pc_en1), .ar_write_en(ar_write_en1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .fetch_ack(fetch_ack1), .data_ack(data_ack1),
        .busy(busy1), .grant_data(grant_data1)
    );

    // {pc_en, ar_write_en, mem_rd, mem_wr, fetch_ack, data_ack, busy, grant_data}
    logic [7:0] obs;
    assign obs = {pc_en, ar_write_en, mem_rd, mem_wr, fetch_ack, data_ack, busy, grant_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset state, and requests ignored while reset is held.
    task automatic test_reset();
        reset     = 1'b1;
        fetch_req = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== 8'b0000_0000) begin
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, 8'b0);
            end else begin
                pass_cnt++;
            end
        end
        total++;
        if ({busy1, grant_data1} !== 2'b00) begin
            $display("FAIL reset_lat1: got %b expected 00", {busy1, grant_data1});
        end else begin
            pass_cnt++;
        end
    endtask

    // Single fetch, MEM_LAT=2, plus the MEM_LAT=1 instance.
    task automatic test_fetch();
        logic [7:0] exp [0:6];
        logic [3:0] exp1 [0:3];
        logic [7:0] m;
        exp  = '{8'b0000_0000, 8'b1000_0010, 8'b0010_0010, 8'b0010_0010,
                 8'b0000_1010, 8'b0000_0000, 8'b0000_0000};
        exp1 = '{4'b0000, 4'b1001, 4'b0101, 4'b0011};
        do_reset();
        fetch_req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            m = exp[c][1] ? 8'hFF : 8'hFE;
            total++;
            if ((obs & m) !== (exp[c] & m)) begin
                $display("FAIL fetch cycle %0d: got %b expected %b", c, obs, exp[c]);
            end else begin
                pass_cnt++;
            end
            if (c <= 3) begin
                total++;
                if ({pc_en1, mem_rd1, fetch_ack1, busy1} !== exp1[c]) begin
                    $display("FAIL fetch_lat1 cycle %0d: got %b expected %b",
                             c, {pc_en1, mem_rd1, fetch_ack1, busy1}, exp1[c]);
                end else begin
                    pass_cnt++;
                end
            end
            if (c == 4) fetch_req = 1'b0;
            tick();
        end
    endtask

    // Single data write.
    task automatic test_data_write();
        logic [7:0] exp [0:5];
        logic [7:0] m;
        exp = '{8'b0000_0000, 8'b0100_0011, 8'b0001_0011, 8'b0001_0011,
                8'b0000_0111, 8'b0000_0000};
        do_reset();
        data_req = 1'b1;
        data_we  = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            m = exp[c][1] ? 8'hFF : 8'hFE;
            total++;
            if ((obs & m) !== (exp[c] & m)) begin
                $display("FAIL data_write cycle %0d: got %b expected %b", c, obs, exp[c]);
            end else begin
                pass_cnt++;
            end
            if (c == 4) data_req = 1'b0;
            tick();
        end
    endtask

    // Data read; data_we flips to 1 during WAIT and must not matter.
    task automatic test_we_latch();
        logic [7:0] exp [0:5];
        logic [7:0] m;
        exp = '{8'b0000_0000, 8'b0100_0011, 8'b0010_0011, 8'b0010_0011,
                8'b0000_0111, 8'b0000_0000};
        do_reset();
        data_req = 1'b1;
        data_we  = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c == 2) data_we = 1'b1;
            m = exp[c][1] ? 8'hFF : 8'hFE;
            total++;
            if ((obs & m) !== (exp[c] & m)) begin
                $display("FAIL we_latch cycle %0d: got %b expected %b", c, obs, exp[c]);
            end else begin
                pass_cnt++;
            end
            if (c == 4) data_req = 1'b0;
            tick();
        end
    endtask

    // Fetch request dropped right after grant still completes.
    task automatic test_drop();
        do_reset();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        total++;
        if (pc_en !== 1'b1) begin
            $display("FAIL drop_load: got pc_en=%b expected 1", pc_en);
        end else begin
            pass_cnt++;
        end
        tick();
        tick();
        tick();
        total++;
        if ({fetch_ack, busy} !== 2'b11) begin
            $display("FAIL drop_ack: got %b expected 11", {fetch_ack, busy});
        end else begin
            pass_cnt++;
        end
    endtask

    // Simultaneous requests after reset: fetch first, then data write.
    task automatic test_tie();
        logic [7:0] exp [0:10];
        logic [7:0] m;
        exp = '{8'b0000_0000, 8'b1000_0010, 8'b0010_0010, 8'b0010_0010,
                8'b0000_1010, 8'b0000_0000, 8'b0100_0011, 8'b0001_0011,
                8'b0001_0011, 8'b0000_0111, 8'b0000_0000};
        do_reset();
        fetch_req = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            m = exp[c][1] ? 8'hFF : 8'hFE;
            total++;
            if ((obs & m) !== (exp[c] & m)) begin
                $display("FAIL tie cycle %0d: got %b expected %b", c, obs, exp[c]);
            end else begin
                pass_cnt++;
            end
            if (c == 4) fetch_req = 1'b0;
            if (c == 9) data_req = 1'b0;
            tick();
        end
    endtask

    // Both requests held: owners alternate, acks at 4, 9, 14, 19.
    task automatic test_back_to_back();
        logic [3:0] e;
        logic [3:0] o;
        do_reset();
        fetch_req = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            e = {(c == 1 || c == 11), (c == 6 || c == 16),
                 (c == 4 || c == 14), (c == 9 || c == 19)};
            o = {pc_en, ar_write_en, fetch_ack, data_ack};
            total++;
            if (o !== e) begin
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, o, e);
            end else begin
                pass_cnt++;
            end
            tick();
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
    endtask

    // Reset in cycle 2 of a fetch abandons it without an ack.
    task automatic test_reset_mid();
        do_reset();
        fetch_req = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_rd, busy} !== 2'b11) begin
            $display("FAIL reset_mid_pre: got %b expected 11", {mem_rd, busy});
        end else begin
            pass_cnt++;
        end
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        fetch_req = 1'b0;
        total++;
        if (obs !== 8'b0000_0000) begin
            $display("FAIL reset_mid_c3: got %b expected %b", obs, 8'b0);
        end else begin
            pass_cnt++;
        end
        for (int c = 4; c <= 8; c++) begin
            tick();
            total++;
            if ({fetch_ack, busy} !== 2'b00) begin
                $display("FAIL reset_mid_after cycle %0d: got %b expected 00", c, {fetch_ack, busy});
            end else begin
                pass_cnt++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        test_reset();
        test_fetch();
        test_data_write();
        test_we_latch();
        test_drop();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter reg_width, default 12: address width of the AR it sequences.
REQ-002 The block SHALL have parameter MEM_LAT, default 2, legal range 1..15: memory access cycles after the AR load.
REQ-003 Port clk, input, 1: the single clock; all state changes on posedge clk.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port fetch_req, input, 1: instruction-fetch request (PC path), level, held until fetch_ack.
REQ-006 Port data_req, input, 1: data-access request (bus path), level, held until data_ack.
REQ-007 Port data_we, input, 1: data access type, 1 = write, 0 = read; sampled with data grant.
REQ-008 Port pc_en, output, 1: drives AR PC_en; loads pc_datain into AR.
REQ-009 Port ar_write_en, output, 1: drives AR write_en; loads bus_datain into AR.
REQ-010 Port mem_rd, output, 1: memory read strobe.
REQ-011 Port mem_wr, output, 1: memory write strobe.
REQ-012 Port fetch_ack, output, 1: one-cycle fetch completion pulse.
REQ-013 Port data_ack, output, 1: one-cycle data completion pulse.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port grant_data, output, 1: current owner, 1 = data, 0 = fetch; valid while busy.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT, DONE; all outputs SHALL be decoded from registered state and grant/type flags only (no input-to-output combinational path).
REQ-017 IDLE: no request -> stay IDLE; one request -> grant it, go LOAD; both -> grant requester not served last (round-robin), go LOAD.
REQ-018 On grant, the block SHALL latch owner into grant_data and, for data, latch data_we; later changes to data_we or requests SHALL NOT affect the transaction.
REQ-019 LOAD: exactly one cycle; pc_en=1 if fetch owner, else ar_write_en=1; never both; counter loaded with MEM_LAT-1; next WAIT.
REQ-020 WAIT: exactly MEM_LAT cycles; mem_rd=1 for fetch or data read, mem_wr=1 for data write; never both; counter decrements each cycle; at counter 0 go DONE.
REQ-021 DONE: exactly one cycle; fetch_ack or data_ack = 1 per owner; last-served flag updated to owner; next IDLE.
REQ-022 Request-sample edge in IDLE to ack cycle SHALL be MEM_LAT+2 cycles; minimum spacing between consecutive LOAD cycles SHALL be MEM_LAT+3.
REQ-023 A request dropped after grant SHALL NOT abort the transaction; the ack still pulses.
REQ-024 pc_en, ar_write_en, mem_rd, mem_wr, fetch_ack, data_ack SHALL be 0 in IDLE.
REQ-025 Counter width SHALL be 4 bits; no wrap is permitted within the legal MEM_LAT range.

Reset
REQ-026 When reset=1 at a clock edge, the next cycle SHALL be IDLE with counter 0, last-served = data (fetch wins first tie), grant_data=0, and all outputs 0.
REQ-027 Reset in any state SHALL abandon the transaction with no ack issued; reset SHALL take priority over all transitions.
REQ-028 While reset is held, requests SHALL be ignored.

Verification
REQ-029 MEM_LAT=2, fetch_req=1 from cycle 0 -> pc_en cycle 1; mem_rd cycles 2-3; fetch_ack cycle 4 only; busy cycles 1-4.
REQ-030 data_req=1, data_we=1 at cycle 0 -> ar_write_en cycle 1; mem_wr cycles 2-3 (mem_rd=0); data_ack cycle 4; grant_data=1 cycles 1-4.
REQ-031 After reset, both requests high at cycle 0 and held until each ack -> fetch served (ack cycle 4), then data (ar_write_en cycle 6, data_ack cycle 9).
REQ-032 Both requests held continuously -> owners alternate F, D, F, D; acks at cycles 4, 9, 14, 19.
REQ-033 reset=1 in cycle 2 during a fetch -> cycle 3 all outputs 0, busy=0, no fetch_ack ever for that transaction.
REQ-034 data read granted, data_we toggled to 1 during WAIT -> mem_rd stays 1, mem_wr stays 0 for the whole transaction.
